// File: rtl/adder_bist_checker.sv
// Built-in self test sequencer for a 4-bit adder: sweeps every {cin,a,b} operand vector,
// waits for the adder to settle, compares against a reference sum and records mismatches.
module adder_bist_checker #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned SWEEP_CIN     = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic       cin,
    input  logic [3:0] sum,
    input  logic       cout,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [9:0] err_count,
    output logic       fail_valid,
    output logic [8:0] first_fail
);

    localparam logic [8:0] LAST_INDEX  = (SWEEP_CIN != 0) ? 9'd511 : 9'd255;
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);
    localparam logic [9:0] ERR_MAX     = 10'h3FF;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        WAIT,
        CHECK,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [8:0]  index_q, index_d;
    logic [7:0]  settleCnt_q, settleCnt_d;
    logic [9:0]  errCount_q, errCount_d;
    logic        failValid_q, failValid_d;
    logic [8:0]  firstFail_q, firstFail_d;

    logic [4:0]  expected;
    logic        mismatch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            index_q     <= '0;
            settleCnt_q <= '0;
            errCount_q  <= '0;
            failValid_q <= 1'b0;
            firstFail_q <= '0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            settleCnt_q <= settleCnt_d;
            errCount_q  <= errCount_d;
            failValid_q <= failValid_d;
            firstFail_q <= firstFail_d;
        end
    end

    // Operands are taken from the index, so they stay put for the whole APPLY..CHECK window.
    always_comb begin
        busy = (state_q == APPLY) || (state_q == WAIT) || (state_q == CHECK);
        done = (state_q == DONE);
        pass = done && (errCount_q == '0);
        a    = busy ? index_q[7:4] : 4'd0;
        b    = busy ? index_q[3:0] : 4'd0;
        cin  = busy & index_q[8];

        err_count  = errCount_q;
        fail_valid = failValid_q;
        first_fail = firstFail_q;

        expected = {1'b0, a} + {1'b0, b} + {4'd0, cin};
        mismatch = ({cout, sum} != expected);
    end

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        settleCnt_d = settleCnt_q;
        errCount_d  = errCount_q;
        failValid_d = failValid_q;
        firstFail_d = firstFail_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = APPLY;
                    index_d     = '0;
                    errCount_d  = '0;
                    failValid_d = 1'b0;
                    firstFail_d = '0;
                end
            end
            APPLY: begin
                state_d     = WAIT;
                settleCnt_d = SETTLE_LOAD;
            end
            WAIT: begin
                if (settleCnt_q <= 8'd1) begin
                    state_d = CHECK;
                end else begin
                    settleCnt_d = settleCnt_q - 8'd1;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    if (errCount_q != ERR_MAX) begin
                        errCount_d = errCount_q + 10'd1;
                    end
                    if (!failValid_q) begin
                        failValid_d = 1'b1;
                        firstFail_d = index_q;
                    end
                end
                if (index_q == LAST_INDEX) begin
                    state_d = DONE;
                end else begin
                    index_d = index_q + 9'd1;
                    state_d = APPLY;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
